// File: rtl/z80_io_pkg.sv
// Register map and control-bit positions shared by the Z80 I/O responder
// and its timer.
package z80_io_pkg;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_RLO  = 2'd1,
    REG_RHI  = 2'd2,
    REG_VEC  = 2'd3
  } reg_sel_e;

  localparam int CTRL_TEN = 0;
  localparam int CTRL_IEN = 1;
  localparam int CTRL_CLR = 7;

  function automatic logic [7:0] read_mux(
    input reg_sel_e    sel,
    input logic        pending,
    input logic [1:0]  ctrl,
    input logic [15:0] reload,
    input logic [7:0]  vector
  );
    case (sel)
      REG_CTRL: read_mux = {pending, 5'b0, ctrl};
      REG_RLO:  read_mux = reload[7:0];
      REG_RHI:  read_mux = reload[15:8];
      default:  read_mux = vector;
    endcase
  endfunction

endpackage

// File: rtl/z80_tick_timer.sv
// 16-bit down-counter that reloads on reaching zero and flags the expiry
// during the clock in which the reload happens.
module z80_tick_timer
  import z80_io_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic [15:0] reload,
  output logic        expire
);

  logic [15:0] count_q, count_d;

  // A software load overrides counting so the new period starts cleanly.
  always_comb begin
    count_d = count_q;
    expire  = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (enable) begin
      if (count_q == 16'd0) begin
        count_d = reload;
        expire  = 1'b1;
      end else begin
        count_d = count_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= 16'hFFFF;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/z80_io_responder.sv
// Z80 bus I/O peripheral: 4-port register window with wait states, a periodic
// timer interrupt and IM2 vector supply during interrupt acknowledge.
module z80_io_responder #(
  parameter logic [7:0] BASE        = 8'h3C,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic [7:0] di,
  output logic [7:0] dout,
  output logic       oe,
  input  logic       m1,
  input  logic       iorq,
  input  logic       rd,
  input  logic       wr,
  output logic       wa1t,
  output logic       intr
);
  import z80_io_pkg::*;

  logic        iorq_q;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [15:0] reload_q, reload_d;
  logic [7:0]  vector_q, vector_d;
  logic        pending_q, pending_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        wa1t_q;
  logic        intr_q;

  logic        start, io_start, ack_start, timer_load, timer_expire, clear;
  reg_sel_e    sel;

  // iorq_q resets low so an iorq held low across reset release is not a start.
  assign start     = !iorq && iorq_q;
  assign io_start  = start && m1 && (a[7:2] == BASE[7:2]);
  assign ack_start = start && !m1 && !intr_q;
  assign sel       = reg_sel_e'(a[1:0]);

  always_comb begin
    ctrl_d     = ctrl_q;
    reload_d   = reload_q;
    vector_d   = vector_q;
    timer_load = 1'b0;
    clear      = ack_start;
    if (io_start && !wr) begin
      case (sel)
        REG_CTRL: begin
          ctrl_d = di[CTRL_IEN:CTRL_TEN];
          clear  = di[CTRL_CLR];
        end
        REG_RLO: reload_d[7:0] = di;
        REG_RHI: begin
          reload_d[15:8] = di;
          timer_load     = 1'b1;
        end
        default: vector_d = di;
      endcase
    end
    // A same-cycle expiry must win over any clear.
    pending_d = pending_q;
    if (clear)        pending_d = 1'b0;
    if (timer_expire) pending_d = 1'b1;
  end

  always_comb begin
    dout_d = dout_q;
    oe_d   = oe_q;
    if (iorq) begin
      dout_d = 8'hFF;
      oe_d   = 1'b0;
    end else if (io_start && !rd) begin
      dout_d = read_mux(sel, pending_q, ctrl_q, reload_q, vector_q);
      oe_d   = 1'b1;
    end else if (ack_start) begin
      dout_d = vector_q;
      oe_d   = 1'b1;
    end
    wcnt_d = wcnt_q;
    if (io_start)              wcnt_d = 8'(WAIT_CYCLES);
    else if (wcnt_q != 8'd0)   wcnt_d = wcnt_q - 8'd1;
  end

  z80_tick_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .enable     (ctrl_q[CTRL_TEN]),
    .load       (timer_load),
    .load_value (reload_d),
    .reload     (reload_q),
    .expire     (timer_expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iorq_q    <= 1'b0;
      ctrl_q    <= 2'b00;
      reload_q  <= 16'hFFFF;
      vector_q  <= 8'hFF;
      pending_q <= 1'b0;
      wcnt_q    <= 8'd0;
      dout_q    <= 8'hFF;
      oe_q      <= 1'b0;
      wa1t_q    <= 1'b1;
      intr_q    <= 1'b1;
    end else begin
      iorq_q    <= iorq;
      ctrl_q    <= ctrl_d;
      reload_q  <= reload_d;
      vector_q  <= vector_d;
      pending_q <= pending_d;
      wcnt_q    <= wcnt_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      wa1t_q    <= (wcnt_d == 8'd0);
      intr_q    <= ~(pending_q & ctrl_q[CTRL_IEN]);
    end
  end

  assign dout = dout_q;
  assign oe   = oe_q;
  assign wa1t = wa1t_q;
  assign intr = intr_q;

endmodule

// File: tb/tb_z80_io_responder.sv
// Self-checking bench for z80_io_responder: randomized bus traffic against a
// register-map model and an arithmetic timer-expiry schedule.
module tb_z80_io_responder;

  localparam int WAIT_CYCLES = 2;
  localparam int HOLD        = WAIT_CYCLES + 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a     = 8'h00;
  logic [7:0] di    = 8'h00;
  logic       m1    = 1'b1;
  logic       iorq  = 1'b1;
  logic       rd    = 1'b1;
  logic       wr    = 1'b1;
  logic [7:0] dout;
  logic       oe, wa1t, intr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Register-map model
  logic [1:0]  m_ctrl;
  logic [15:0] m_reload;
  logic [7:0]  m_vec;
  logic        m_pending;

  // Timer schedule: expiries at t_first + k*t_per; intr low from m_fall on
  int t_first, t_per, m_fall;

  // Results of the last bus cycle
  logic [7:0] r_data, r_dout_after;
  logic       r_intr_next, r_oe_after;
  int         r_waits, r_oes, r_start;

  z80_io_responder #(.BASE(8'h3C), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clock (clock),
    .reset (reset),
    .a     (a),
    .di    (di),
    .dout  (dout),
    .oe    (oe),
    .m1    (m1),
    .iorq  (iorq),
    .rd    (rd),
    .wr    (wr),
    .wa1t  (wa1t),
    .intr  (intr)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit is_exp(input int c);
    return (c >= t_first) && (((c - t_first) % t_per) == 0);
  endfunction

  function automatic int next_exp(input int c);
    if (c < t_first) return t_first;
    return t_first + ((c - t_first) / t_per + 1) * t_per;
  endfunction

  function automatic logic [7:0] model_read(input int r);
    case (r)
      0:       return {m_pending, 5'b0, m_ctrl};
      1:       return m_reload[7:0];
      2:       return m_reload[15:8];
      default: return m_vec;
    endcase
  endfunction

  task automatic model_write(input int r, input logic [7:0] d);
    case (r)
      0: begin m_ctrl = d[1:0]; if (d[7]) m_pending = 1'b0; end
      1: m_reload[7:0]  = d;
      2: m_reload[15:8] = d;
      default: m_vec = d;
    endcase
  endtask

  // One I/O or acknowledge cycle, entered and left on a falling clock edge.
  // start_at > 0 places the starting rising edge on that cycle number.
  task automatic bus_cycle(input logic is_ack, input logic is_wr,
                           input logic [7:0] addr, input logic [7:0] wdata,
                           input int start_at);
    while (start_at > 0 && cyc < start_at - 1) @(negedge clock);
    a    = addr;
    di   = wdata;
    m1   = ~is_ack;
    wr   = ~(is_wr & ~is_ack);
    rd   = ~(~is_wr & ~is_ack);
    iorq = 1'b0;
    r_start = cyc + 1;
    r_waits = 0;
    r_oes   = 0;
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clock);
      if (wa1t === 1'b0) r_waits++;
      if (oe === 1'b1)   r_oes++;
      if (i == 0) r_data = dout;
      if (i == 1) r_intr_next = intr;
    end
    iorq = 1'b1; m1 = 1'b1; rd = 1'b1; wr = 1'b1;
    @(negedge clock);
    r_dout_after = dout;
    r_oe_after   = oe;
  endtask

  task automatic poll_intr_low(output int entry, output int at);
    int n;
    entry = cyc;
    n = 0;
    while (intr !== 1'b0 && n < 300) begin @(negedge clock); n++; end
    at = (intr === 1'b0) ? cyc : -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (dout !== 8'hFF || oe !== 1'b0 || wa1t !== 1'b1 || intr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got do=%h oe=%b wait=%b int=%b expected FF 0 1 1", dout, oe, wa1t, intr);
    end
    reset = 1'b1;
    @(negedge clock);
    m_ctrl = 2'b00; m_reload = 16'hFFFF; m_vec = 8'hFF; m_pending = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus_cycle(1'b0, 1'b0, 8'h3C | 8'(r), 8'h00, 0);
      checks++;
      if (r_data !== model_read(r)) begin
        errors++;
        $display("[TB] FAIL reset_reg%0d: got %h expected %h", r, r_data, model_read(r));
      end
    end
  endtask

  task automatic test_register_rw();
    int r;
    logic [7:0] d;
    for (int k = 0; k < 10; k++) begin
      r = $urandom_range(0, 3);
      d = 8'($urandom);
      if (r == 0) d = d & 8'h02;
      bus_cycle(1'b0, 1'b1, 8'h3C | 8'(r), d, 0);
      model_write(r, d);
      checks++;
      if (r_waits != WAIT_CYCLES || r_oes != 0) begin
        errors++;
        $display("[TB] FAIL write_handshake: got waits=%0d oe_cycles=%0d expected %0d 0", r_waits, r_oes, WAIT_CYCLES);
      end
      r = $urandom_range(0, 3);
      bus_cycle(1'b0, 1'b0, 8'h3C | 8'(r), 8'h00, 0);
      checks++;
      if (r_data !== model_read(r)) begin
        errors++;
        $display("[TB] FAIL readback_reg%0d: got %h expected %h", r, r_data, model_read(r));
      end
      checks++;
      if (r_waits != WAIT_CYCLES || r_oes != HOLD || r_oe_after !== 1'b0 || r_dout_after !== 8'hFF) begin
        errors++;
        $display("[TB] FAIL read_handshake: got waits=%0d oe_cycles=%0d oe_after=%b do_after=%h expected %0d %0d 0 FF",
                 r_waits, r_oes, r_oe_after, r_dout_after, WAIT_CYCLES, HOLD);
      end
    end
    bus_cycle(1'b0, 1'b1, 8'h3C, 8'h00, 0);
    model_write(0, 8'h00);
  endtask

  task automatic test_out_of_window();
    logic [7:0] x;
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      x = 8'h40;
      else if (k == 1) x = 8'h3B;
      else begin
        x = 8'($urandom);
        while (x[7:2] == 6'h0F) x = 8'($urandom);
      end
      bus_cycle(1'b0, 1'b1, x, 8'($urandom), 0);
      checks++;
      if (r_waits != 0 || r_oes != 0) begin
        errors++;
        $display("[TB] FAIL outside_write_%h: got waits=%0d oe_cycles=%0d expected 0 0", x, r_waits, r_oes);
      end
      bus_cycle(1'b0, 1'b0, x, 8'h00, 0);
      checks++;
      if (r_waits != 0 || r_oes != 0 || r_data !== 8'hFF) begin
        errors++;
        $display("[TB] FAIL outside_read_%h: got waits=%0d oe_cycles=%0d do=%h expected 0 0 FF", x, r_waits, r_oes, r_data);
      end
    end
    for (int r = 0; r < 4; r++) begin
      bus_cycle(1'b0, 1'b0, 8'h3C | 8'(r), 8'h00, 0);
      checks++;
      if (r_data !== model_read(r)) begin
        errors++;
        $display("[TB] FAIL outside_keeps_reg%0d: got %h expected %h", r, r_data, model_read(r));
      end
    end
  endtask

  task automatic test_timer_irq();
    int rl, entry, at, want, target;
    logic [7:0] vec;
    rl  = $urandom_range(6, 10);
    vec = 8'($urandom);
    bus_cycle(1'b0, 1'b1, 8'h3F, vec, 0);
    m_vec = vec;
    bus_cycle(1'b0, 1'b1, 8'h3D, 8'(rl), 0);
    bus_cycle(1'b0, 1'b1, 8'h3E, 8'h00, 0);
    m_reload = 16'(rl);
    bus_cycle(1'b0, 1'b1, 8'h3C, 8'h03, 0);
    m_ctrl  = 2'b11;
    // Count holds rl at the enabling edge, then needs rl+1 more edges to expire.
    t_first = r_start + rl + 1;
    t_per   = rl + 1;
    m_fall  = t_first + 1;
    poll_intr_low(entry, at);
    want = (entry > m_fall) ? entry : m_fall;
    checks++;
    if (at != want) begin
      errors++;
      $display("[TB] FAIL first_expiry: intr low at cycle %0d expected %0d", at, want);
    end

    bus_cycle(1'b0, 1'b0, 8'h3C, 8'h00, 0);
    checks++;
    if (r_data !== 8'h83 || r_waits != WAIT_CYCLES || r_oes != HOLD || r_oe_after !== 1'b0 || r_dout_after !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL status_read: got do=%h waits=%0d oe_cycles=%0d oe_after=%b do_after=%h expected 83 %0d %0d 0 FF",
               r_data, r_waits, r_oes, r_oe_after, r_dout_after, WAIT_CYCLES, HOLD);
    end

    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, rl)) @(negedge clock);
      bus_cycle(1'b1, 1'b0, 8'h00, 8'h00, 0);
      checks++;
      if (r_data !== vec || r_oes != HOLD || r_waits != 0) begin
        errors++;
        $display("[TB] FAIL ack_vector: got do=%h oe_cycles=%0d waits=%0d expected %h %0d 0", r_data, r_oes, r_waits, vec, HOLD);
      end
      checks++;
      if (r_intr_next !== (is_exp(r_start) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("[TB] FAIL ack_intr: got %b expected %b", r_intr_next, is_exp(r_start) ? 1'b0 : 1'b1);
      end
      if (!is_exp(r_start)) m_fall = next_exp(r_start) + 1;
      poll_intr_low(entry, at);
      want = (entry > m_fall) ? entry : m_fall;
      checks++;
      if (at != want) begin
        errors++;
        $display("[TB] FAIL reexpiry_%0d: intr low at cycle %0d expected %0d", k, at, want);
      end
    end

    target = next_exp(cyc + 2);
    bus_cycle(1'b1, 1'b0, 8'h00, 8'h00, target);
    checks++;
    if (r_start != target || r_intr_next !== 1'b0 || r_data !== vec) begin
      errors++;
      $display("[TB] FAIL ack_vs_expiry: got start=%0d intr=%b do=%h expected %0d 0 %h", r_start, r_intr_next, r_data, target, vec);
    end

    target = next_exp(cyc + 2);
    bus_cycle(1'b0, 1'b1, 8'h3C, 8'h83, target);
    checks++;
    if (r_start != target || r_intr_next !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_vs_expiry: got start=%0d intr=%b expected %0d 0", r_start, r_intr_next, target);
    end
    bus_cycle(1'b0, 1'b0, 8'h3C, 8'h00, 0);
    checks++;
    if (r_data !== 8'h83) begin
      errors++;
      $display("[TB] FAIL clear_vs_expiry_status: got %h expected 83", r_data);
    end

    target = next_exp(cyc + 2) + 1;
    bus_cycle(1'b0, 1'b1, 8'h3C, 8'h83, target);
    checks++;
    if (r_intr_next !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_pending: intr got %b expected 1", r_intr_next);
    end
    m_fall = next_exp(target) + 1;
    poll_intr_low(entry, at);
    want = (entry > m_fall) ? entry : m_fall;
    checks++;
    if (at != want) begin
      errors++;
      $display("[TB] FAIL after_clear_expiry: intr low at cycle %0d expected %0d", at, want);
    end

    bus_cycle(1'b0, 1'b1, 8'h3C, 8'h01, 0);
    bus_cycle(1'b0, 1'b0, 8'h3C, 8'h00, 0);
    checks++;
    if (r_data !== 8'h81 || intr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL int_disable_keeps_pending: got status=%h intr=%b expected 81 1", r_data, intr);
    end

    target = next_exp(cyc + 2) + 1;
    bus_cycle(1'b0, 1'b1, 8'h3C, 8'h80, target);
    m_ctrl = 2'b00; m_pending = 1'b0;
    bus_cycle(1'b0, 1'b0, 8'h3C, 8'h00, 0);
    checks++;
    if (r_data !== model_read(0) || intr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timer_stop: got status=%h intr=%b expected %h 1", r_data, intr, model_read(0));
    end
  endtask

  task automatic test_ack_ignored();
    bus_cycle(1'b1, 1'b0, 8'h00, 8'h00, 0);
    checks++;
    if (r_oes != 0 || r_data !== 8'hFF || r_waits != 0 || r_intr_next !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ack_without_int: got oe_cycles=%0d do=%h waits=%0d intr=%b expected 0 FF 0 1",
               r_oes, r_data, r_waits, r_intr_next);
    end
  endtask

  task automatic test_reset_mid_access();
    int entry, at, bad;
    bus_cycle(1'b0, 1'b1, 8'h3D, 8'h01, 0);
    bus_cycle(1'b0, 1'b1, 8'h3E, 8'h00, 0);
    bus_cycle(1'b0, 1'b1, 8'h3C, 8'h03, 0);
    poll_intr_low(entry, at);
    checks++;
    if (at < 0) begin
      errors++;
      $display("[TB] FAIL mid_setup_intr: intr never went low, got %b expected 0", intr);
    end
    a = 8'h3C; m1 = 1'b1; rd = 1'b0; iorq = 1'b0;
    @(negedge clock);
    checks++;
    if (wa1t !== 1'b0 || oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_access_active: got wait=%b oe=%b expected 0 1", wa1t, oe);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dout !== 8'hFF || oe !== 1'b0 || wa1t !== 1'b1 || intr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset: got do=%h oe=%b wait=%b int=%b expected FF 0 1 1", dout, oe, wa1t, intr);
    end
    @(negedge clock);
    reset = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (oe !== 1'b0 || wa1t !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL held_iorq_after_reset: responded in %0d cycles expected 0", bad);
    end
    iorq = 1'b1;
    @(negedge clock);
    iorq = 1'b0;
    @(negedge clock);
    checks++;
    if (oe !== 1'b1 || dout !== 8'h00 || wa1t !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_start_after_reset: got oe=%b do=%h wait=%b expected 1 00 0", oe, dout, wa1t);
    end
    iorq = 1'b1; rd = 1'b1;
    @(negedge clock);
    checks++;
    if (oe !== 1'b0 || dout !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL release_after_reset: got oe=%b do=%h expected 0 FF", oe, dout);
    end
  endtask

  initial begin
    test_reset();
    test_register_rw();
    test_out_of_window();
    test_timer_irq();
    test_ack_ignored();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
